// File: rtl/md_unit_if.sv
// Multiply/divide unit bus: E-stage request, busy to the hazard unit, HI/LO to the result mux.
interface md_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, flush, a, b,
        input  busy, hi, lo
    );

    modport slave (
        input  start, md_op, flush, a, b,
        output busy, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// MIPS E-stage multiply/divide unit owning HI/LO; results commit when the busy window ends.
// Optional madd/msub (md_op 6/7) built only when MD_UNIT_MADD_EN is defined.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    md_unit_if.slave   bus
);

    localparam int unsigned DW      = 32;
    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MD_UNIT_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             wr_q, wr_d;
    logic [DW-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic [DW-1:0]    hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;

    logic             long_c, accept_c, div_zero_c, div_ovf_c;
    logic [DW-1:0]    b_us_c, b_ss_c, quot_u_c, rem_u_c;
    logic signed [DW-1:0]   quot_s_c, rem_s_c;
    logic signed [2*DW-1:0] prod_s_c;
    logic [2*DW-1:0]        prod_u_c;

    // Operation decode; unsupported opcodes are never accepted
    always_comb begin
        long_c = 1'b0;
        case (bus.md_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: long_c = 1'b1;
`ifdef MD_UNIT_MADD_EN
            OP_MADD, OP_MSUB:                   long_c = 1'b1;
`endif
            default:                            long_c = 1'b0;
        endcase
    end

    assign accept_c = bus.start & ~bus.flush & ~busy_q &
                      (long_c | (bus.md_op == OP_MTHI) | (bus.md_op == OP_MTLO));

    // Arithmetic datapath
    assign prod_s_c = $signed({{DW{bus.a[DW-1]}}, bus.a}) * $signed({{DW{bus.b[DW-1]}}, bus.b});
    assign prod_u_c = {{DW{1'b0}}, bus.a} * {{DW{1'b0}}, bus.b};

    // Divisor forced to 1 for b==0 (result discarded) and for MIN/-1, where a/1 is the wanted answer
    assign div_zero_c = (bus.b == '0);
    assign div_ovf_c  = (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);
    assign b_us_c     = div_zero_c ? DW'(1) : bus.b;
    assign b_ss_c     = (div_zero_c | div_ovf_c) ? DW'(1) : bus.b;
    assign quot_u_c   = bus.a / b_us_c;
    assign rem_u_c    = bus.a % b_us_c;
    assign quot_s_c   = $signed(bus.a) / $signed(b_ss_c);
    assign rem_s_c    = $signed(bus.a) % $signed(b_ss_c);

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            wr_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_tmp_q <= '0;
            lo_tmp_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            wr_q     <= wr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_c && long_c) state_d = S_RUN;
            S_RUN:   if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        wr_d     = wr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    case (bus.md_op)
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        OP_MULT: begin
                            {hi_tmp_d, lo_tmp_d} = prod_s_c;
                            wr_d  = 1'b1;
                            cnt_d = CNT_W'(MULT_CYCLES);
                        end
                        OP_MULTU: begin
                            {hi_tmp_d, lo_tmp_d} = prod_u_c;
                            wr_d  = 1'b1;
                            cnt_d = CNT_W'(MULT_CYCLES);
                        end
                        OP_DIV: begin
                            hi_tmp_d = rem_s_c;
                            lo_tmp_d = quot_s_c;
                            wr_d     = ~div_zero_c;
                            cnt_d    = CNT_W'(DIV_CYCLES);
                        end
                        OP_DIVU: begin
                            hi_tmp_d = rem_u_c;
                            lo_tmp_d = quot_u_c;
                            wr_d     = ~div_zero_c;
                            cnt_d    = CNT_W'(DIV_CYCLES);
                        end
`ifdef MD_UNIT_MADD_EN
                        OP_MADD: begin
                            {hi_tmp_d, lo_tmp_d} = {hi_q, lo_q} + prod_s_c;
                            wr_d  = 1'b1;
                            cnt_d = CNT_W'(MULT_CYCLES);
                        end
                        OP_MSUB: begin
                            {hi_tmp_d, lo_tmp_d} = {hi_q, lo_q} - prod_s_c;
                            wr_d  = 1'b1;
                            cnt_d = CNT_W'(MULT_CYCLES);
                        end
`endif
                        default: ;
                    endcase
                    busy_d = long_c;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_d = 1'b0;
                    wr_d   = 1'b0;
                    if (wr_q) begin
                        hi_d = hi_tmp_q;
                        lo_d = lo_tmp_q;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO queued at issue, popped when busy falls.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    res_t sb_q[$];
    res_t exp_r;
    logic [31:0] mdl_hi = '0;
    logic [31:0] mdl_lo = '0;

    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Present one request for one edge; caller sits between edges, returns at edge+1
    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fl);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.a     = a;
        bus.b     = b;
        bus.flush = fl;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
    endtask

    // Reference model of the architectural result, pushed to the scoreboard
    task automatic predict(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        logic [31:0] ua, ub, q, r;
        res_t e;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        e = {mdl_hi, mdl_lo};
        case (op)
            3'd0: e = p;
            3'd1: e = {32'd0, a} * {32'd0, b};
            3'd2: if (b != 0) begin
                ua = a[31] ? -a : a;
                ub = b[31] ? -b : b;
                q  = ua / ub;
                r  = ua % ub;
                e.lo = (a[31] ^ b[31]) ? -q : q;
                e.hi = a[31] ? -r : r;
            end
            3'd3: if (b != 0) begin
                e.lo = a / b;
                e.hi = a % b;
            end
`ifdef MD_UNIT_MADD_EN
            3'd6: e = {mdl_hi, mdl_lo} + p;
            3'd7: e = {mdl_hi, mdl_lo} - p;
`endif
            default: ;
        endcase
        {mdl_hi, mdl_lo} = e;
        sb_q.push_back(e);
    endtask

    // Count busy samples from now; flag any HI/LO movement while busy
    task automatic run_busy(output int cyc, output bit changed);
        logic [31:0] h0, l0;
        h0 = bus.hi;
        l0 = bus.lo;
        cyc = 0;
        changed = 1'b0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (bus.hi !== h0 || bus.lo !== l0) changed = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic long_op(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_cyc);
        int cyc;
        bit chg;
        predict(op, a, b);
        drive(op, a, b, 1'b0);
        run_busy(cyc, chg);
        checks++;
        if (cyc !== exp_cyc) begin
            errors++;
            $display("FAIL %s_busy_cycles: got %0d expected %0d", name, cyc, exp_cyc);
        end
        checks++;
        if (chg !== 1'b0) begin
            errors++;
            $display("FAIL %s_hilo_stable: hi/lo moved while busy", name);
        end
        exp_r = sb_q.pop_front();
        checks++;
        if ({bus.hi, bus.lo} !== exp_r) begin
            errors++;
            $display("FAIL %s_result: got hi=%h lo=%h expected hi=%h lo=%h",
                     name, bus.hi, bus.lo, exp_r.hi, exp_r.lo);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.flush = 1'b0; bus.md_op = '0; bus.a = '0; bus.b = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.hi, bus.lo} !== 65'd0) begin
            errors++;
            $display("FAIL reset_values: got busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.hi, bus.lo);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        long_op("mult",  3'd0, 32'hFFFF_FFFE, 32'd3, MC);
        long_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, MC);
    endtask

    task automatic test_div();
        long_op("div",     3'd2, 32'hFFFF_FFF9, 32'd2, DC);
        long_op("divu_z",  3'd3, 32'd7, 32'd0, DC);
        long_op("div_z",   3'd2, 32'h8000_0001, 32'd0, DC);
        long_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DC);
        long_op("divu_big",3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC);
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] h0;
        h0 = bus.hi;
        drive(3'd4, 32'h1234_5678, 32'd0, 1'b1);
        checks++;
        if (bus.hi !== h0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi_flush: got hi=%h busy=%b expected hi=%h busy=0", bus.hi, bus.busy, h0);
        end
        drive(3'd4, 32'h1234_5678, 32'd0, 1'b0);
        checks++;
        if (bus.hi !== 32'h1234_5678 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi: got hi=%h busy=%b expected hi=12345678 busy=0", bus.hi, bus.busy);
        end
        drive(3'd5, 32'hCAFE_F00D, 32'd0, 1'b0);
        checks++;
        if (bus.lo !== 32'hCAFE_F00D || bus.hi !== 32'h1234_5678 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: got hi=%h lo=%h busy=%b expected hi=12345678 lo=cafef00d busy=0",
                     bus.hi, bus.lo, bus.busy);
        end
        mdl_hi = 32'h1234_5678;
        mdl_lo = 32'hCAFE_F00D;
    endtask

    task automatic test_flush_long();
        bit seen;
        drive(3'd0, 32'd3, 32'd4, 1'b1);
        seen = 1'b0;
        repeat (4) begin
            if (bus.busy !== 1'b0 || bus.hi !== mdl_hi || bus.lo !== mdl_lo) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_long: flushed mult changed state (hi=%h lo=%h busy=%b)",
                     bus.hi, bus.lo, bus.busy);
        end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        bit chg, seen;
        predict(3'd0, 32'd7, 32'd9);
        drive(3'd0, 32'd7, 32'd9, 1'b0);
        // Second request plus a flush pulse during RUN; both must be ignored
        bus.start = 1'b1; bus.md_op = 3'd2; bus.a = 32'd100; bus.b = 32'd7; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        run_busy(cyc, chg);
        checks++;
        if (cyc + 1 !== MC) begin
            errors++;
            $display("FAIL busy_ignore_cycles: got %0d expected %0d", cyc + 1, MC);
        end
        exp_r = sb_q.pop_front();
        checks++;
        if ({bus.hi, bus.lo} !== exp_r) begin
            errors++;
            $display("FAIL busy_ignore_result: got hi=%h lo=%h expected hi=%h lo=%h",
                     bus.hi, bus.lo, exp_r.hi, exp_r.lo);
        end
        seen = 1'b0;
        repeat (15) begin
            if (bus.busy !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_second: got busy=1 after commit expected busy=0");
        end
    endtask

    task automatic test_back_to_back();
        long_op("b2b_mult", 3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, MC);
        long_op("b2b_div",  3'd2, 32'd100, 32'hFFFF_FFF9, DC);
        long_op("b2b_multu",3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC);
    endtask

    task automatic test_madd();
`ifdef MD_UNIT_MADD_EN
        long_op("madd", 3'd6, 32'hFFFF_FFFE, 32'd3, MC);
        long_op("msub", 3'd7, 32'd1000, 32'd1000, MC);
`else
        bit seen;
        seen = 1'b0;
        drive(3'd6, 32'd5, 32'd5, 1'b0);
        repeat (3) begin
            if (bus.busy !== 1'b0 || bus.hi !== mdl_hi || bus.lo !== mdl_lo) seen = 1'b1;
            @(posedge clk); #1;
        end
        drive(3'd7, 32'd5, 32'd5, 1'b0);
        repeat (3) begin
            if (bus.busy !== 1'b0 || bus.hi !== mdl_hi || bus.lo !== mdl_lo) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL madd_noop: op 6/7 changed state (hi=%h lo=%h busy=%b)", bus.hi, bus.lo, bus.busy);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            long_op("rnd_mult", 3'd0, a, b, MC);
            long_op("rnd_divu", 3'd3, a, b >> $urandom_range(0, 28), DC);
            long_op("rnd_div",  3'd2, a, b >> $urandom_range(0, 28), DC);
        end
    endtask

    task automatic test_reset_mid();
        drive(3'd2, 32'd1000, 32'd3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.hi, bus.lo} !== 65'd0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.hi, bus.lo);
        end
        mdl_hi = '0;
        mdl_lo = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        long_op("post_reset_mult", 3'd0, 32'd5, 32'd6, MC);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_flush_long();
        test_start_while_busy();
        test_back_to_back();
        test_madd();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the five-stage MIPS pipeline, sitting in the E stage beside the ALU. It owns the HI/LO registers and executes mult, multu, div, divu, mthi and mtlo. It exports `start` and `busy` directly to the hazard unit, which uses them to stall mfhi, mflo and further multiply/divide instructions in D. HI/LO are read combinationally by the E-stage result mux for mfhi/mflo.

## Interface
Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10: busy cycles for div/divu (≥1).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle strobe: a multiply/divide instruction is valid in E this cycle; also routed to the hazard unit.
- md_op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 msub (6/7 are legal only with the macro in Configuration).
- flush  in  1  E-stage instruction squashed by an exception or interrupt; qualifies `start`.
- a  in  32  rs operand, already forwarded.
- b  in  32  rt operand, already forwarded.
- busy  out  1  operation in progress; routed to the hazard unit.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- Accept occurs when `start & ~flush & ~busy` is high at a clock edge.
- Accepted mthi: `hi <= a` at that edge. `busy` stays 0.
- Accepted mtlo: `lo <= a` at that edge. `busy` stays 0.
- Accepted mult/multu/div/divu: at the accept edge, the result is computed and latched into internal `hi_tmp`/`lo_tmp`. The counter is loaded with MULT_CYCLES or DIV_CYCLES, and `busy` is set to 1.
- State machine has two states:
  - IDLE → RUN on an accepted long operation.
  - RUN: the counter decrements on each edge. On the edge where the counter equals 1: `hi <= hi_tmp`, `lo <= lo_tmp`, `busy <= 0`, and the state returns to IDLE.
- Arithmetic rules:
  - mult: {hi,lo} = signed a × signed b (64-bit).
  - multu: {hi,lo} = unsigned a × unsigned b (64-bit).
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient in lo, remainder in hi.
  - div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
  - Divide by zero (b == 0): `busy` runs the full DIV_CYCLES, but HI/LO are not written.
- Boundary conditions:
  - `start` while `busy` is 1: ignored, with no state change. The hazard unit guarantees this never occurs; the bench checks it anyway.
  - `flush` with `start`: nothing is accepted, and HI/LO are untouched.
  - `flush` during RUN: has no effect. An operation already in flight always completes and commits.
  - Reset mid-operation: the operation aborts, and every output and register takes its reset value.

## Timing
- Reset values: `busy` = 0, `hi` = 0, `lo` = 0, state IDLE, counter 0, `hi_tmp`/`lo_tmp` = 0.
- mthi/mtlo: new value is visible on `hi`/`lo` one cycle after the accept edge (zero busy cycles).
- mult, accepted at edge T: `busy` is high for edges T+1 through T+MULT_CYCLES. The new `hi`/`lo` are visible after edge T+MULT_CYCLES, in the same cycle `busy` reads 0.
- div: same pattern with DIV_CYCLES.
- Back-to-back: a new `start` in the cycle where `busy` has just fallen is accepted.
- `hi`/`lo` never change while `busy` is 1. Readers see either the old value or the fully committed new value.

## Configuration
- Macro: `MD_UNIT_MADD_EN`.
- Defined:
  - md_op 6 (madd): {hi,lo} <= {hi,lo} + signed a×b.
  - md_op 7 (msub): {hi,lo} <= {hi,lo} − signed a×b.
  - Both use MULT_CYCLES. The accumulation base is the HI/LO value at the accept edge.
- Undefined: md_op 6/7 are treated as no-ops. They are not accepted, `busy` stays 0, and no multiply-accumulate hardware is built.

## Test plan
- Reset: assert `rst_n` = 0 mid-div, then release → `busy` = 0, `hi` = `lo` = 0 immediately, and the next op behaves normally.
- mult a = 0xFFFFFFFE (−2), b = 3 → `busy` high exactly 5 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFFA.
- multu on the same operands → hi = 0x00000002, lo = 0xFFFFFFFA.
- div a = −7, b = 2 → `busy` high 10 cycles, then lo = 0xFFFFFFFD (−3), hi = 0xFFFFFFFF (−1).
- divu a = 7, b = 0 → `busy` high 10 cycles; hi/lo keep their prior values.
- mthi a = 0x12345678 with `flush` = 1 → hi unchanged. Repeat with `flush` = 0 → hi = 0x12345678 next cycle, `busy` never asserted.
- During a mult, pulse `start` with div → ignored. Mult result commits after 5 cycles, and no second busy period follows.
